// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    // Host-to-device transfer phases. StAck is kept in the encoding for the
    // receive side; the transmitter resolves the ack directly in StStop.
    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StData,
        StParity,
        StStop,
        StAck,
        StRelease
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       error;
    logic       rx_inhibit;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  done,
        input  error,
        input  rx_inhibit
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output done,
        output error,
        output rx_inhibit
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a registered falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic line_in,
    output logic level,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;

    // Idle PS/2 lines are high, so the chain resets to 1 and no edge is seen at startup.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ack and line release.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    // Never hold the clock low for less than the 100 us a device needs to notice.
    localparam int unsigned InhibitMin  = CLK_FREQ_HZ / 10_000;
    localparam int unsigned InhibitReq  = (INHIBIT_CYCLES > InhibitMin) ? INHIBIT_CYCLES
                                                                        : InhibitMin;
    localparam int unsigned InhibitLen  = (InhibitReq > 2) ? InhibitReq : 2;
    localparam int unsigned CntMax      = (TIMEOUT_CYCLES > InhibitLen) ? TIMEOUT_CYCLES
                                                                        : InhibitLen;
    localparam int unsigned CntW        = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] InhibitLast = CntW'(InhibitLen - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t   state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            clk_oe_q;
    logic            data_oe_q;
    logic            done_q;
    logic            error_q;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic unused_data_fall;
    logic waiting;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .clrn    (clrn),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .clrn    (clrn),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (unused_data_fall)
    );

    // States in which the device owns the clock and a stall must time out.
    assign waiting = state_q inside {StRts, StData, StParity, StStop, StRelease};

    // Transfer sequencer; all line drives and pulses are registered here.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (waiting && cnt_q == TimeoutLast) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                error_q   <= 1'b1;
                cnt_q     <= '0;
                state_q   <= StIdle;
            end else begin
                if (waiting) begin
                    cnt_q <= clk_fall ? '0 : cnt_q + CntW'(1);
                end
                case (state_q)
                    StIdle: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        cnt_q     <= '0;
                        if (tx.tx_valid) begin
                            shift_q  <= tx.tx_data;
                            parity_q <= odd_parity(tx.tx_data);
                            clk_oe_q <= 1'b1;
                            state_q  <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == InhibitLast) begin
                            clk_oe_q <= 1'b0;
                            cnt_q    <= '0;
                            state_q  <= StRts;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                            // Start bit goes out one cycle before the clock is released.
                            if (cnt_q == InhibitLast - CntW'(1)) begin
                                data_oe_q <= 1'b1;
                            end
                        end
                    end
                    StRts: begin
                        if (clk_fall) begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= 4'd1;
                            state_q   <= StData;
                        end
                    end
                    StData: begin
                        if (clk_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                data_oe_q <= ~parity_q;
                                state_q   <= StParity;
                            end else begin
                                data_oe_q <= ~shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (clk_fall) begin
                            data_oe_q <= 1'b0;
                            state_q   <= StStop;
                        end
                    end
                    StStop: begin
                        if (clk_fall) begin
                            if (!data_level) begin
                                state_q <= StRelease;
                            end else begin
                                error_q <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StRelease: begin
                        if (clk_level && data_level) begin
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                endcase
            end
        end
    end

    assign tx.tx_ready   = (state_q == StIdle);
    assign tx.rx_inhibit = (state_q != StIdle);
    assign tx.done       = done_q;
    assign tx.error      = error_q;
    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_data_oe   = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: PS/2 device model on wired-AND lines plus a per-cycle output monitor.
module tb_ps2_host_tx;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned INH    = 120;
    localparam int unsigned TO     = 1500;

    logic clk = 1'b0;
    logic clrn;
    logic dev_clk;
    logic dev_data;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic ps2_clk_line;
    logic ps2_data_line;

    ps2_host_tx_if bus ();

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx          (bus),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int rts_cyc = 0;
    int run = 0;
    int starts = 0;
    int exp_starts = 0;
    bit mon_en = 1'b0;
    bit prev_end = 1'b0;
    bit prev_clk_oe = 1'b0;
    bit prev_data_oe = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            cyc++;
            check("ready_vs_inhibit", {31'd0, bus.tx_ready}, {31'd0, ~bus.rx_inhibit});
            if (bus.done || bus.error) begin
                check("done_err_excl", {31'd0, bus.done & bus.error}, 0);
                check("end_ready", {31'd0, bus.tx_ready}, 1);
                check("end_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
            end
            if (bus.done) done_cnt++;
            if (bus.error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (prev_end && bus.tx_valid) check("b2b_inhibit_next", {31'd0, ps2_clk_oe}, 1);
            if (ps2_clk_oe && !prev_clk_oe) starts++;
            if (ps2_clk_oe) run++;
            if (!ps2_clk_oe && prev_clk_oe) begin
                check("inhibit_len", run, INH);
                check("start_before_release", {31'd0, prev_data_oe}, 1);
                rts_cyc = cyc;
                run = 0;
            end
            prev_end     = bus.done || bus.error;
            prev_clk_oe  = ps2_clk_oe;
            prev_data_oe = ps2_data_oe;
        end
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        // Levels after falls 1..10: data LSB first, odd parity, stop.
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!bus.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", {31'd0, bus.tx_ready}, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        exp_starts++;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Device side of one host-to-device frame; abort_at pulses clrn after that fall.
    task automatic device_xfer(input logic [7:0] b, input bit ack, input int half,
                               input int abort_at, output logic [9:0] got);
        logic [9:0] exp;
        int w;
        exp = frame_of(b);
        got = '0;
        w = 0;
        while (ps2_clk_line && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("inhibit_seen", {31'd0, ps2_clk_line}, 0);
        w = 0;
        while (!ps2_clk_line && w < INH + 50) begin
            @(negedge clk);
            w++;
        end
        check("rts_clk_released", {31'd0, ps2_clk_line}, 1);
        check("start_bit", {31'd0, ps2_data_line}, 0);
        repeat ($urandom_range(5, 20)) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            if (k <= 10) begin
                repeat (4) @(negedge clk);
                check($sformatf("bit_latency_%0d", k), {31'd0, ps2_data_line},
                      {31'd0, exp[k-1]});
                if (k == abort_at) begin
                    clrn = 1'b0;
                    @(negedge clk);
                    clrn = 1'b1;
                    check("abort_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                    dev_clk = 1'b1;
                    return;
                end
                repeat (half - 4) @(negedge clk);
                got[k-1] = ps2_data_line;
            end else begin
                repeat (half) @(negedge clk);
            end
            dev_clk = 1'b1;
            repeat (half) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic expect_end(input int d0, input int e0, input bit ack, input string nm);
        int w = 0;
        while (done_cnt + err_cnt == d0 + e0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_done"}, done_cnt - d0, {31'd0, ack});
        check({nm, "_error"}, err_cnt - e0, {31'd0, ~ack});
    endtask

    task automatic check_frame(input logic [7:0] b, input logic [9:0] got, input string nm);
        logic [9:0] exp;
        exp = frame_of(b);
        check({nm, "_data"}, {24'd0, got[7:0]}, {24'd0, exp[7:0]});
        check({nm, "_parity"}, {31'd0, got[8]}, {31'd0, exp[8]});
        check({nm, "_stop"}, {31'd0, got[9]}, 1);
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input int half,
                            input string nm, output logic [9:0] got);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        device_xfer(b, ack, half, -1, got);
        if (ack) check_frame(b, got, nm);
        expect_end(d0, e0, ack, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got;
        logic [7:0] b;
        bit ack;
        int d0;
        int e0;
        int s0;
        int w;

        clrn = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
        check("rst_ready", {31'd0, bus.tx_ready}, 1);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_error", {31'd0, bus.error}, 0);
        check("rst_inhibit", {31'd0, bus.rx_inhibit}, 0);
        clrn = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Hand-computed frames pin the model.
        run_xfer(8'hED, 1'b1, 40, "ed", got);
        check("ed_literal", {22'd0, got}, {22'd0, 10'b11_1110_1101});
        run_xfer(8'hF4, 1'b1, 40, "f4", got);
        check("f4_parity_literal", {31'd0, got[8]}, 0);
        run_xfer(8'h00, 1'b1, 40, "z0", got);
        check("z0_parity_literal", {31'd0, got[8]}, 1);

        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_xfer(b, ack, $urandom_range(30, 50), $sformatf("rnd%0d", i), got);
        end

        // Device leaves data high on the 11th edge.
        run_xfer(8'hEE, 1'b0, 40, "nack", got);

        // Device never clocks.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hFF);
        w = 0;
        while (err_cnt == e0 && w < INH + TO + 200) begin
            @(negedge clk);
            w++;
        end
        check("timeout_error", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_latency", err_cyc - rts_cyc, TO);
        check("timeout_ready", {31'd0, bus.tx_ready}, 1);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);

        // Reset while bit 4 is on the line, then a clean transfer.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        device_xfer(8'hED, 1'b1, 40, 5, got);
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_error", err_cnt - e0, 0);
        check("abort_ready", {31'd0, bus.tx_ready}, 1);
        run_xfer(8'hEE, 1'b1, 40, "post_rst", got);

        // Valid held across done: second byte starts back-to-back, busy byte ignored.
        d0 = done_cnt;
        e0 = err_cnt;
        s0 = starts;
        bus.tx_data = 8'h5A;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'hC3;
        device_xfer(8'h5A, 1'b1, 40, -1, got);
        check_frame(8'h5A, got, "b2b_first");
        expect_end(d0, e0, 1'b1, "b2b_first");
        @(negedge clk);
        bus.tx_valid = 1'b0;
        exp_starts += 2;
        @(negedge clk);
        check("b2b_started", starts - s0, 2);
        d0 = done_cnt;
        e0 = err_cnt;
        device_xfer(8'hC3, 1'b1, 40, -1, got);
        check_frame(8'hC3, got, "b2b_second");
        expect_end(d0, e0, 1'b1, "b2b_second");

        repeat (40) @(negedge clk);
        check("total_starts", starts, exp_starts);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
